// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down counting, wrap or saturate at the
// limits, parallel load with range checking, and a one-cycle carry/borrow pulse.
module bcd_mod_counter #(
    parameter int MODULUS = 60,
    parameter bit WRAP    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       pause,
    input  logic       dir,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       at_limit,
    output logic       load_err
);

    localparam logic [3:0] TENS_TOP = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] ONES_TOP = 4'((MODULUS - 1) % 10);
    localparam logic [7:0] MOD_V    = 8'(MODULUS);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_carry;
    logic       r_load_err;

    logic       w_at_max;
    logic       w_at_zero;
    logic       w_count;
    logic [7:0] w_load_val;
    logic       w_load_ok;
    logic [3:0] w_up_ones;
    logic [3:0] w_up_tens;
    logic [3:0] w_dn_ones;
    logic [3:0] w_dn_tens;

    assign w_at_max  = (r_tens == TENS_TOP) && (r_ones == ONES_TOP);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_count   = tick && !pause;

    // 10*tens computed as 8*tens + 2*tens; an out-of-range digit still fits in 8 bits.
    assign w_load_val = ({4'd0, load_tens} << 3) + ({4'd0, load_tens} << 1)
                      + {4'd0, load_ones};
    assign w_load_ok  = (load_ones <= 4'd9) && (load_tens <= 4'd9)
                      && (w_load_val < MOD_V);

    // Per-digit increment/decrement; tens only moves on a ones rollover.
    always_comb begin
        w_up_ones = r_ones + 4'd1;
        w_up_tens = r_tens;
        if (r_ones == 4'd9) begin
            w_up_ones = 4'd0;
            w_up_tens = r_tens + 4'd1;
        end
        w_dn_ones = r_ones - 4'd1;
        w_dn_tens = r_tens;
        if (r_ones == 4'd0) begin
            w_dn_ones = 4'd9;
            w_dn_tens = r_tens - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
            if (clr) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end else if (load) begin
                if (w_load_ok) begin
                    r_ones <= load_ones;
                    r_tens <= load_tens;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_count) begin
                if (dir) begin
                    if (!w_at_max) begin
                        r_ones <= w_up_ones;
                        r_tens <= w_up_tens;
                    end else if (WRAP) begin
                        r_ones  <= 4'd0;
                        r_tens  <= 4'd0;
                        r_carry <= 1'b1;
                    end
                end else begin
                    if (!w_at_zero) begin
                        r_ones <= w_dn_ones;
                        r_tens <= w_dn_tens;
                    end else if (WRAP) begin
                        r_ones  <= ONES_TOP;
                        r_tens  <= TENS_TOP;
                        r_carry <= 1'b1;
                    end
                end
            end
        end
    end

    assign ones     = r_ones;
    assign tens     = r_tens;
    assign carry    = r_carry;
    assign load_err = r_load_err;
    assign at_limit = dir ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: four instances (60 wrap, 24 wrap, 60 saturate,
// 7 wrap) share one stimulus bus; each check targets a single instance.
module tb_bcd_mod_counter;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       pause;
    logic       dir;
    logic       clr;
    logic       load;
    logic [3:0] load_ones;
    logic [3:0] load_tens;

    logic [3:0] ones_w  [4];
    logic [3:0] tens_w  [4];
    logic       carry_w [4];
    logic       lim_w   [4];
    logic       err_w   [4];

    int checks   = 0;
    int failures = 0;

    localparam int D60 = 0;
    localparam int D24 = 1;
    localparam int DSAT = 2;
    localparam int D7 = 3;

    bcd_mod_counter #(.MODULUS(60), .WRAP(1'b1)) u_m60 (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .dir(dir),
        .clr(clr), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones_w[0]), .tens(tens_w[0]), .carry(carry_w[0]),
        .at_limit(lim_w[0]), .load_err(err_w[0]));

    bcd_mod_counter #(.MODULUS(24), .WRAP(1'b1)) u_m24 (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .dir(dir),
        .clr(clr), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones_w[1]), .tens(tens_w[1]), .carry(carry_w[1]),
        .at_limit(lim_w[1]), .load_err(err_w[1]));

    bcd_mod_counter #(.MODULUS(60), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .dir(dir),
        .clr(clr), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones_w[2]), .tens(tens_w[2]), .carry(carry_w[2]),
        .at_limit(lim_w[2]), .load_err(err_w[2]));

    bcd_mod_counter #(.MODULUS(7), .WRAP(1'b1)) u_m7 (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .dir(dir),
        .clr(clr), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones_w[3]), .tens(tens_w[3]), .carry(carry_w[3]),
        .at_limit(lim_w[3]), .load_err(err_w[3]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic       tick;
        logic       pause;
        logic       dir;
        logic [3:0] lt;
        logic [3:0] lo;
        logic [3:0] et;
        logic [3:0] eo;
        logic       ec;
        logic       ee;
        logic       el;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_dut(input int d, input string nm, input logic [3:0] et,
                           input logic [3:0] eo, input logic ec, input logic ee,
                           input logic el);
        chk({nm, ".value"}, {tens_w[d], ones_w[d]}, {et, eo});
        chk({nm, ".carry"}, {7'd0, carry_w[d]}, {7'd0, ec});
        chk({nm, ".load_err"}, {7'd0, err_w[d]}, {7'd0, ee});
        chk({nm, ".at_limit"}, {7'd0, lim_w[d]}, {7'd0, el});
    endtask

    // driver: present inputs at negedge, sample 1 ns after the active edge
    task automatic step(input logic c, input logic l, input logic t, input logic p,
                        input logic d, input logic [3:0] lt, input logic [3:0] lo);
        @(negedge clk);
        clr = c; load = l; tick = t; pause = p; dir = d;
        load_tens = lt; load_ones = lo;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] lt, input logic [3:0] lo, input logic d);
        step(1'b0, 1'b1, 1'b0, 1'b0, d, lt, lo);
    endtask

    task automatic do_tick(input logic d);
        step(1'b0, 1'b0, 1'b1, 1'b0, d, 4'd0, 4'd0);
    endtask

    task automatic do_clr(input logic d);
        step(1'b1, 1'b0, 1'b0, 1'b0, d, 4'd0, 4'd0);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; pause = 1'b0; dir = 1'b1;
        clr = 1'b0; load = 1'b0; load_ones = 4'd0; load_tens = 4'd0;

        //                clr load tick pause dir  lt     lo     et    eo    ec    ee    el
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8, 4'd5, 4'd8, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 4'd8, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd7, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'hA, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1});

        // reset state, held across clock edges
        repeat (3) @(posedge clk);
        #1;
        chk_dut(D60, "reset_m60", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_dut(D24, "reset_m24", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // table-driven vectors against the MODULUS=60 wrap instance
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].clr, vq[i].load, vq[i].tick, vq[i].pause, vq[i].dir,
                 vq[i].lt, vq[i].lo);
            chk_dut(D60, $sformatf("vec%0d", i), vq[i].et, vq[i].eo,
                    vq[i].ec, vq[i].ee, vq[i].el);
        end

        // truncated modulus 24
        do_load(4'd1, 4'd9, 1'b1);
        chk_dut(D24, "m24_load19", 4'd1, 4'd9, 1'b0, 1'b0, 1'b0);
        do_tick(1'b1);
        chk_dut(D24, "m24_up20", 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        do_load(4'd2, 4'd3, 1'b1);
        chk_dut(D24, "m24_load23", 4'd2, 4'd3, 1'b0, 1'b0, 1'b1);
        do_tick(1'b1);
        chk_dut(D24, "m24_wrap", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        do_load(4'd2, 4'd4, 1'b1);
        chk_dut(D24, "m24_load24_rej", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        do_load(4'd1, 4'hA, 1'b1);
        chk_dut(D24, "m24_loadA_rej", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        do_tick(1'b0);
        chk_dut(D24, "m24_borrow", 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
        do_load(4'd2, 4'd0, 1'b0);
        do_tick(1'b0);
        chk_dut(D24, "m24_down19", 4'd1, 4'd9, 1'b0, 1'b0, 1'b0);

        // saturating instance
        do_load(4'd5, 4'd9, 1'b1);
        do_tick(1'b1);
        chk_dut(DSAT, "sat_top", 4'd5, 4'd9, 1'b0, 1'b0, 1'b1);
        do_clr(1'b0);
        do_tick(1'b0);
        chk_dut(DSAT, "sat_bottom", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        do_tick(1'b1);
        chk_dut(DSAT, "sat_up1", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);

        // single-digit modulus 7
        do_clr(1'b0);
        do_tick(1'b0);
        chk_dut(D7, "m7_borrow", 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
        do_load(4'd0, 4'd7, 1'b1);
        chk_dut(D7, "m7_load7_rej", 4'd0, 4'd6, 1'b0, 1'b1, 1'b1);
        do_tick(1'b1);
        chk_dut(D7, "m7_wrap", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // async reset while carry is high, no clock edge in between
        do_load(4'd5, 4'd9, 1'b1);
        do_tick(1'b1);
        chk_dut(D60, "pre_reset_carry", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        do_load(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        load = 1'b0;
        tick = 1'b1;
        dir = 1'b1;
        load_tens = 4'd5;
        load_ones = 4'd9;
        @(posedge clk);
        #1;
        chk({"pre_reset2.value"}, {tens_w[D60], ones_w[D60]}, 8'h34);
        @(negedge clk);
        tick = 1'b0;
        load = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        load = 1'b0;
        tick = 1'b1;
        @(posedge clk);
        #1;
        chk_dut(D60, "carry_before_reset", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk({"carry_m24_before_reset"}, {7'd0, carry_w[D24]}, 8'd0);
        tick = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk_dut(D60, "async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        do_tick(1'b1);
        chk_dut(D60, "after_reset_tick", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter. Generalises the stopwatch minutes/seconds digit pairs into one block.
- Modulus is configurable. Counting can go up or down, with wrap or saturate selectable.
- Provides synchronous clear, parallel load with validity checking, and registered carry/borrow for cascading.
- Sits between the tick/enable generator and the seven-segment display mux. Instances cascade via carry into the next unit's tick.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1. Legal values are 2..100.
- WRAP, 1, boundary behaviour. 1 = wrap around at the limit; 0 = saturate at the limit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle count-enable pulse.
- pause  input  1  1 = ignore tick (hold).
- dir  input  1  1 = count up, 0 = count down. Sampled with tick.
- clr  input  1  synchronous clear to 00.
- load  input  1  synchronous parallel load.
- load_ones  input  4  BCD ones digit to load.
- load_tens  input  4  BCD tens digit to load.
- ones  output  4  ones digit, 0..9.
- tens  output  4  tens digit, 0..(MODULUS-1)/10.
- carry  output  1  registered pulse on wrap or borrow.
- at_limit  output  1  combinational; 1 when count is MODULUS-1 (dir=1) or 00 (dir=0).
- load_err  output  1  registered pulse; load value was rejected.

Behaviour:
- **Reset (reset=0, asynchronous):** ones=0, tens=0, carry=0, load_err=0. Everything is held until reset=1.
- **Count value:** V = 10*tens + ones. V is always in 0..MODULUS-1. Both digits are always valid BCD.
- **Priority per rising edge:** clr > load > (tick & ~pause) > hold.
- **clr:** V←0. carry=0 and load_err=0 that cycle.
- **load:** accepted only if load_ones≤9, load_tens≤9 and 10*load_tens+load_ones < MODULUS.
  - Accepted: V←loaded value, load_err=0.
  - Rejected: V unchanged, load_err=1 for one cycle.
  - A load never asserts carry.
- **Count up (tick & ~pause & dir=1):**
  - V<MODULUS-1: V←V+1. The ones 9→0 rollover increments tens.
  - V=MODULUS-1, WRAP=1: V←0 and carry=1 for one cycle.
  - V=MODULUS-1, WRAP=0: V holds, carry=0.
- **Count down (tick & ~pause & dir=0):**
  - V>0: V←V-1. The ones 0→9 rollover decrements tens.
  - V=0, WRAP=1: V←MODULUS-1 and carry=1 for one cycle.
  - V=0, WRAP=0: V holds, carry=0.
- **Latency and outputs:**
  - Digits update on the same edge that samples tick. carry and load_err are registered on that same edge.
  - carry and load_err are 0 on every cycle where their condition did not occur. They never stretch beyond one cycle.
- **pause:**
  - pause=1 with tick=1: no change, carry=0.
  - pause does not block clr or load.
- **Simultaneous events:**
  - clr with load: clr wins, load_err=0.
  - load with tick: load wins, tick is dropped.
- **Reset mid-operation:** a pending carry pulse is cleared immediately. The first tick after release acts from V=0.
- **Non-multiple-of-10 moduli:** the top digit pair is truncated correctly. Example: MODULUS=24 wraps 23→00, and ones never exceeds 3 when tens=2.
- **MODULUS<10:** tens stays at 0.
- Digit arithmetic is performed per digit, never via binary-to-BCD conversion.

Test Plan:
1. **Reset and up-wrap (MODULUS=60, WRAP=1):** reset=0 → 00, carry=0. Load 58, tick twice with dir=1 → 59, then 00 with carry=1 for exactly one cycle.
2. **Down-borrow:** from 00, tick with dir=0 → 59, carry=1. Tick again → 58, carry=0. Load 10, tick dir=0 → 09.
3. **Truncated modulus (MODULUS=24):** load 19, tick → 20. Load 23, tick → 00 with carry. Load 24 → load_err=1 and value unchanged. Load ones=0xA → load_err=1.
4. **Saturate (MODULUS=60, WRAP=0):**
   - At 59, tick with dir=1 → stays 59, carry=0, at_limit=1.
   - At 00, tick with dir=0 → stays 00, carry=0.
5. **Priority:**
   - clr+load+tick at 37 → 00.
   - load(12)+tick → 12.
   - pause=1 with 5 ticks → value unchanged. clr while paused → 00.
6. **Async reset mid-pulse:** assert reset=0 in the same cycle carry=1 → outputs 0 immediately, without waiting for a clock edge. Release, then tick → 01.
